// File: rtl/instr_mem_fetch_port_if.sv
// Fetch-port bundle: byte preload port, request channel and response channel.
// The memory is the slave. Whoever drives requests and preloads is the master.
interface instr_mem_fetch_port_if #(
    parameter int ADDR_W = 8
);
    logic              load_en;
    logic              load_we;
    logic [ADDR_W-1:0] load_addr;
    logic [7:0]        load_data;
    logic              req_valid;
    logic              req_ready;
    logic [ADDR_W-1:0] req_addr;
    logic              rsp_valid;
    logic              rsp_ready;
    logic [31:0]       rsp_instr;
    logic              rsp_fault;
    logic [ADDR_W-1:0] rsp_addr;

    modport slave (
        input  load_en, load_we, load_addr, load_data,
        input  req_valid, req_addr, rsp_ready,
        output req_ready, rsp_valid, rsp_instr, rsp_fault, rsp_addr
    );

    modport master (
        output load_en, load_we, load_addr, load_data,
        output req_valid, req_addr, rsp_ready,
        input  req_ready, rsp_valid, rsp_instr, rsp_fault, rsp_addr
    );
endinterface

// File: rtl/instr_mem_fetch_port.sv
// Byte-addressed instruction memory with a one-cycle registered fetch port.
// Each response carries one big-endian word and a fault flag for misaligned or out-of-range requests.
module instr_mem_fetch_port #(
    parameter int DEPTH_BYTES = 256,
    parameter int ADDR_W      = 8,
    parameter int ALIGN_CHECK = 1
) (
    input  logic                   i_clk,
    input  logic                   i_reset,
    instr_mem_fetch_port_if.slave  bus
);
    // Highest address at which a full 4-byte word still fits without wrapping.
    localparam logic [31:0] LAST_WORD = 32'(DEPTH_BYTES - 4);

    logic [7:0] Mem [0:DEPTH_BYTES-1];

    logic              r_rsp_valid;
    logic [31:0]       r_rsp_instr;
    logic              r_rsp_fault;
    logic [ADDR_W-1:0] r_rsp_addr;

    logic              w_req_ready;
    logic              w_accept;
    logic              w_misalign;
    logic              w_range;
    logic              w_fault;
    logic [ADDR_W-1:0] w_a1;
    logic [ADDR_W-1:0] w_a2;
    logic [ADDR_W-1:0] w_a3;
    logic [31:0]       w_rd_word;

    // The port can take a request only if the response slot is empty or is being drained this cycle.
    assign w_req_ready = !i_reset && !bus.load_en && (!r_rsp_valid || bus.rsp_ready);
    assign w_accept    = bus.req_valid && w_req_ready;

    // Byte addresses may wrap here. A wrapped read is always replaced by a fault response.
    assign w_a1 = bus.req_addr + ADDR_W'(1);
    assign w_a2 = bus.req_addr + ADDR_W'(2);
    assign w_a3 = bus.req_addr + ADDR_W'(3);
    assign w_rd_word = {Mem[bus.req_addr], Mem[w_a1], Mem[w_a2], Mem[w_a3]};

    assign w_misalign = (ALIGN_CHECK != 0) && (bus.req_addr[1:0] != 2'b00);
    assign w_range    = 32'(bus.req_addr) > LAST_WORD;
    assign w_fault    = w_misalign || w_range;

    // Preload writes ignore reset, so a boot loader write in the reset cycle still lands.
    always_ff @(posedge i_clk) begin
        if (bus.load_en && bus.load_we) begin
            Mem[bus.load_addr] <= bus.load_data;
        end
    end

    // Response register: load on accept, clear valid on consume, otherwise hold (stall).
    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            r_rsp_valid <= 1'b0;
            r_rsp_instr <= 32'h0;
            r_rsp_fault <= 1'b0;
            r_rsp_addr  <= '0;
        end else if (w_accept) begin
            r_rsp_valid <= 1'b1;
            r_rsp_instr <= w_fault ? 32'h0 : w_rd_word;
            r_rsp_fault <= w_fault;
            r_rsp_addr  <= bus.req_addr;
        end else if (r_rsp_valid && bus.rsp_ready) begin
            r_rsp_valid <= 1'b0;
        end
    end

    assign bus.req_ready = w_req_ready;
    assign bus.rsp_valid = r_rsp_valid;
    assign bus.rsp_instr = r_rsp_instr;
    assign bus.rsp_fault = r_rsp_fault;
    assign bus.rsp_addr  = r_rsp_addr;
endmodule
